// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLTU = 3'd5,
    OP_MULU = 3'd6,
    OP_DIVU = 3'd7
  } aluOp_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } aluState_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide core, one step per cycle, WIDTH steps.
// done flags the step that completes the operation; resLo/resHi carry that step's result.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             done,
  output logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] resHi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0]   bReg;
  logic               isDivReg;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     sum;

  always_comb begin
    // Divide: shift the next dividend bit into the partial remainder, keep the
    // difference only when it does not borrow. With opB=0 this naturally yields
    // an all-ones quotient and a remainder equal to the dividend.
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, bReg};
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bReg} : {(WIDTH+1){1'b0}});
    if (isDivReg) begin
      stepAcc = diff[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      stepAcc = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      bReg     <= '0;
      isDivReg <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, opA};
      bReg     <= opB;
      isDivReg <= isDiv;
      cnt      <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc <= stepAcc;
      cnt <= cnt - CW'(1);
    end
  end

  assign done  = (cnt == CW'(1));
  assign resLo = stepAcc[WIDTH-1:0];
  assign resHi = stepAcc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: simple ops complete in 1 cycle, mulu/divu in WIDTH cycles with busy high.
// start is only accepted while not busy; requests during busy are dropped, not queued.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  aluState_e        state, nextState;
  logic [WIDTH-1:0] simpleRes;
  logic             isSimple;
  logic             coreStart, coreDone;
  logic [WIDTH-1:0] coreLo, coreHi;
  logic             divZeroPend;

  assign isSimple  = (op != OP_MULU) && (op != OP_DIVU);
  assign coreStart = (state == S_IDLE) && start && !isSimple;
  assign busy      = (state == S_CALC);

  always_comb begin
    simpleRes = '0;
    case (aluOp_e'(op))
      OP_ADD:  simpleRes = inA + inB;
      OP_SUB:  simpleRes = inA - inB;
      OP_AND:  simpleRes = inA & inB;
      OP_OR:   simpleRes = inA | inB;
      OP_XOR:  simpleRes = inA ^ inB;
      OP_SLTU: simpleRes = WIDTH'(inA < inB);
      default: simpleRes = '0;
    endcase
  end

  // FINISH is never held: the last CALC step already writes the results, so
  // the controller returns straight to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (start && !isSimple) nextState = S_CALC;
      S_CALC:  if (coreDone) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      ans         <= '0;
      hi          <= '0;
      div_zero    <= 1'b0;
      divZeroPend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        div_zero    <= 1'b0;
        divZeroPend <= (op == OP_DIVU) && (inB == '0);
        if (isSimple) begin
          ans  <= simpleRes;
          hi   <= '0;
          done <= 1'b1;
        end
      end else if (state == S_CALC && coreDone) begin
        ans      <= coreLo;
        hi       <= coreHi;
        done     <= 1'b1;
        div_zero <= divZeroPend;
      end
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) uCore (
    .clk   (clk),
    .reset (reset),
    .start (coreStart),
    .isDiv (op == OP_DIVU),
    .opA   (inA),
    .opB   (inB),
    .done  (coreDone),
    .resLo (coreLo),
    .resHi (coreHi)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] ans, hi;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .ans(ans), .hi(hi), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {divZero, hi, ans} computed directly from the operation definitions.
  function automatic logic [2*W:0] model(input int o, input int a, input int b);
    int r, h, dz;
    r = 0; h = 0; dz = 0;
    case (o)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? 1 : 0;
      6: begin r = (a * b) % 256; h = (a * b) / 256; end
      default: begin
        if (b == 0) begin r = 255; h = a; dz = 1; end
        else begin r = a / b; h = a % b; end
      end
    endcase
    return {dz[0], h[W-1:0], r[W-1:0]};
  endfunction

  task automatic runOp(input int o, input int a, input int b, input bit noisy);
    logic [2*W:0] e;
    e = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = 3'(o); inA = W'(a); inB = W'(b);
    @(posedge clk); #1;
    if (o < 6) begin
      chk("simple_done", done, 1);
      chk("simple_busy", busy, 0);
      chk("simple_ans", ans, e[W-1:0]);
      chk("simple_hi", hi, e[2*W-1:W]);
      chk("simple_dz", div_zero, 0);
    end else begin
      chk("md_busy_start", busy, 1);
      chk("md_done_start", done, 0);
      for (int i = 1; i <= W; i++) begin
        @(negedge clk);
        if (noisy) begin
          start = 1'(($urandom % 2));
          op = 3'($urandom); inA = W'($urandom); inB = W'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        if (i < W) begin
          chk("md_busy_mid", busy, 1);
          chk("md_done_mid", done, 0);
        end else begin
          chk("md_busy_end", busy, 0);
          chk("md_done_end", done, 1);
          chk("md_ans", ans, e[W-1:0]);
          chk("md_hi", hi, e[2*W-1:W]);
          chk("md_dz", div_zero, e[2*W]);
        end
      end
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ans", ans, 0);
    chk("rst_hi", hi, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    runOp(0, 8'hF0, 8'h20, 0);
    runOp(1, 8'h05, 8'h07, 0);
    runOp(5, 8'h03, 8'h80, 0);
    runOp(5, 8'h80, 8'h03, 0);
    runOp(2, 8'hCC, 8'hAA, 0);
    runOp(3, 8'hCC, 8'hAA, 0);
    runOp(4, 8'hCC, 8'hAA, 0);
    idleCycle();
    runOp(6, 8'hFF, 8'hFF, 0);
    idleCycle();
    runOp(7, 200, 7, 0);
    runOp(7, 8'h35, 0, 0);
    idleCycle();
    // add issued while mulu is busy must be dropped; next op starts in the done cycle
    runOp(6, 8'hC3, 8'h5A, 1);
    runOp(0, 8'h11, 8'h22, 0);
    runOp(7, 8'hFE, 8'h10, 0);
    runOp(6, 8'h07, 8'h09, 0);

    // reset three cycles into a divide
    @(negedge clk);
    start = 1'b1; op = 3'd7; inA = 8'h9C; inB = 8'h05;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ans", ans, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_dz", div_zero, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W + 2; i++) idleCycle();
    runOp(6, 3, 5, 0);

    for (int n = 0; n < 60; n++) begin
      int o, a, b;
      o = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      runOp(o, a, b, 1'($urandom % 2));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
